// File: rtl/id_pkg.sv
// Shared definitions for the ID/EX decode back end.
// Contents:
//   - default field widths and the bubble counter width
//   - id_state_e  : interlock FSM states (RUN / BUBBLE)
//   - fwd_sel_e   : operand source selected by the forwarding mux
//   - fwd_select(): forwarding priority rule (EX > MEM > register file)
package id_pkg;

  localparam int unsigned WORD_W_DEF    = 32;
  localparam int unsigned ADDR_W_DEF    = 30;
  localparam int unsigned REG_W_DEF     = 5;
  localparam int unsigned ALU_OP_W_DEF  = 4;
  localparam int unsigned MEM_OP_W_DEF  = 2;
  localparam int unsigned CTRL_OP_W_DEF = 2;
  localparam int unsigned EXP_W_DEF     = 3;

  // Holds LD_LAT-1 for LD_LAT in 1..7.
  localparam int unsigned BUB_CNT_W = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } id_state_e;

  typedef enum logic [1:0] {
    FWD_GPR = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  // The younger producer (EX) wins when EX and MEM both target the register.
  function automatic fwd_sel_e fwd_select(input logic use_op,
                                          input logic ex_hit,
                                          input logic mem_hit);
    if (use_op && ex_hit)       return FWD_EX;
    else if (use_op && mem_hit) return FWD_MEM;
    else                        return FWD_GPR;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand forwarding mux.
// Ports:
//   use_op          : operand is actually read by the instruction
//   rs, gpr_data    : source register address and register-file read data
//   ex_*            : EX-stage producer (loads are excluded, their data is not ready)
//   mem_*           : MEM-stage producer
//   data            : resolved operand value
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic              use_op,
  input  logic [REG_W-1:0]  rs,
  input  logic [WORD_W-1:0] gpr_data,
  input  logic              ex_en,
  input  logic [REG_W-1:0]  ex_dst_addr,
  input  logic              ex_gpr_we_,
  input  logic              ex_is_load,
  input  logic [WORD_W-1:0] ex_fwd_data,
  input  logic              mem_en,
  input  logic [REG_W-1:0]  mem_dst_addr,
  input  logic              mem_gpr_we_,
  input  logic [WORD_W-1:0] mem_fwd_data,
  output logic [WORD_W-1:0] data
);

  logic     ex_hit;
  logic     mem_hit;
  fwd_sel_e sel;

  assign ex_hit  = ex_en & ~ex_gpr_we_ & ~ex_is_load & (ex_dst_addr == rs);
  assign mem_hit = mem_en & ~mem_gpr_we_ & (mem_dst_addr == rs);

  // NOTE: every output of a combinational block gets a value on every path
  // (here via the default arm) so no latch is inferred.
  always_comb begin
    sel = fwd_select(use_op, ex_hit, mem_hit);
    unique case (sel)
      FWD_EX:  data = ex_fwd_data;
      FWD_MEM: data = mem_fwd_data;
      default: data = gpr_data;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode-stage back end: resolves operands by forwarding, holds the decoder
// off during load-use interlock bubbles, and registers the bundle into the
// ID/EX boundary behind a valid/ready handshake with a 1-entry skid buffer.
// Ports:
//   clk, reset (sync, active-high), flush (sync kill), stall (freeze all state)
//   dec_*       : decoder bundle input with dec_valid/dec_ready handshake
//   gpr_rd_data_0/1 : register-file read data for dec_rs0/dec_rs1
//   ex_*, mem_* : forwarding sources from EX and MEM
//   ld_hazard   : combinational load-use hazard on the current decoder bundle
//   id_ready    : EX accepts id_* this cycle
//   id_en, id_* : registered ID/EX bundle
// Interlock timing: the cycle that detects ld_hazard holds the instruction,
// then LD_LAT BUBBLE cycles follow before the decoder is accepted again.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned REG_W     = REG_W_DEF,
  parameter int unsigned ALU_OP_W  = ALU_OP_W_DEF,
  parameter int unsigned MEM_OP_W  = MEM_OP_W_DEF,
  parameter int unsigned CTRL_OP_W = CTRL_OP_W_DEF,
  parameter int unsigned EXP_W     = EXP_W_DEF,
  parameter int unsigned LD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [ADDR_W-1:0]    dec_pc,
  input  logic [REG_W-1:0]     dec_rs0,
  input  logic [REG_W-1:0]     dec_rs1,
  input  logic                 dec_use0,
  input  logic                 dec_use1,
  input  logic [WORD_W-1:0]    gpr_rd_data_0,
  input  logic [WORD_W-1:0]    gpr_rd_data_1,
  input  logic                 dec_imm_sel,
  input  logic [WORD_W-1:0]    dec_imm,
  input  logic [ALU_OP_W-1:0]  dec_alu_op,
  input  logic [MEM_OP_W-1:0]  dec_mem_op,
  input  logic [CTRL_OP_W-1:0] dec_ctrl_op,
  input  logic [EXP_W-1:0]     dec_exp_code,
  input  logic                 dec_br_flag,
  input  logic [REG_W-1:0]     dec_dst_addr,
  input  logic                 dec_gpr_we_,
  input  logic                 ex_en,
  input  logic [REG_W-1:0]     ex_dst_addr,
  input  logic                 ex_gpr_we_,
  input  logic                 ex_is_load,
  input  logic [WORD_W-1:0]    ex_fwd_data,
  input  logic                 mem_en,
  input  logic [REG_W-1:0]     mem_dst_addr,
  input  logic                 mem_gpr_we_,
  input  logic [WORD_W-1:0]    mem_fwd_data,
  output logic                 ld_hazard,
  input  logic                 id_ready,
  output logic                 id_en,
  output logic [ADDR_W-1:0]    id_pc,
  output logic [ALU_OP_W-1:0]  id_alu_op,
  output logic [WORD_W-1:0]    id_alu_in_0,
  output logic [WORD_W-1:0]    id_alu_in_1,
  output logic                 id_br_flag,
  output logic [MEM_OP_W-1:0]  id_mem_op,
  output logic [WORD_W-1:0]    id_mem_wr_data,
  output logic [CTRL_OP_W-1:0] id_ctrl_op,
  output logic [REG_W-1:0]     id_dst_addr,
  output logic                 id_gpr_we_,
  output logic [EXP_W-1:0]     id_exp_code
);

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [ALU_OP_W-1:0]  alu_op;
    logic [WORD_W-1:0]    alu_in_0;
    logic [WORD_W-1:0]    alu_in_1;
    logic                 br_flag;
    logic [MEM_OP_W-1:0]  mem_op;
    logic [WORD_W-1:0]    mem_wr_data;
    logic [CTRL_OP_W-1:0] ctrl_op;
    logic [REG_W-1:0]     dst_addr;
    logic                 gpr_we_;
    logic [EXP_W-1:0]     exp_code;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = '{gpr_we_: 1'b1, default: '0};
  localparam logic [BUB_CNT_W-1:0] BUB_INIT = BUB_CNT_W'(LD_LAT - 1);
  localparam logic [BUB_CNT_W-1:0] BUB_ONE  = BUB_CNT_W'(1);

  id_state_e            state;
  logic [BUB_CNT_W-1:0] bub_cnt;
  logic                 skid_full;
  bundle_t              skid;
  bundle_t              out_q;

  logic [WORD_W-1:0]    op0;
  logic [WORD_W-1:0]    op1;
  bundle_t              in_bundle;
  logic                 accept;
  logic                 out_load;

  id_fwd_mux #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd0 (
    .use_op       (dec_use0),
    .rs           (dec_rs0),
    .gpr_data     (gpr_rd_data_0),
    .ex_en        (ex_en),
    .ex_dst_addr  (ex_dst_addr),
    .ex_gpr_we_   (ex_gpr_we_),
    .ex_is_load   (ex_is_load),
    .ex_fwd_data  (ex_fwd_data),
    .mem_en       (mem_en),
    .mem_dst_addr (mem_dst_addr),
    .mem_gpr_we_  (mem_gpr_we_),
    .mem_fwd_data (mem_fwd_data),
    .data         (op0)
  );

  id_fwd_mux #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd1 (
    .use_op       (dec_use1),
    .rs           (dec_rs1),
    .gpr_data     (gpr_rd_data_1),
    .ex_en        (ex_en),
    .ex_dst_addr  (ex_dst_addr),
    .ex_gpr_we_   (ex_gpr_we_),
    .ex_is_load   (ex_is_load),
    .ex_fwd_data  (ex_fwd_data),
    .mem_en       (mem_en),
    .mem_dst_addr (mem_dst_addr),
    .mem_gpr_we_  (mem_gpr_we_),
    .mem_fwd_data (mem_fwd_data),
    .data         (op1)
  );

  // The store data is always the forwarded operand 1, even when the ALU
  // takes the immediate on its second input.
  always_comb begin
    in_bundle             = BUNDLE_RST;
    in_bundle.pc          = dec_pc;
    in_bundle.alu_op      = dec_alu_op;
    in_bundle.alu_in_0    = op0;
    in_bundle.alu_in_1    = dec_imm_sel ? dec_imm : op1;
    in_bundle.br_flag     = dec_br_flag;
    in_bundle.mem_op      = dec_mem_op;
    in_bundle.mem_wr_data = op1;
    in_bundle.ctrl_op     = dec_ctrl_op;
    in_bundle.dst_addr    = dec_dst_addr;
    in_bundle.gpr_we_     = dec_gpr_we_;
    in_bundle.exp_code    = dec_exp_code;
  end

  assign ld_hazard = dec_valid & ex_en & ex_is_load & ~ex_gpr_we_ &
                     ((dec_use0 & (dec_rs0 == ex_dst_addr)) |
                      (dec_use1 & (dec_rs1 == ex_dst_addr)));

  assign dec_ready = ~stall & ~skid_full & (state == ST_RUN) & ~ld_hazard;
  assign accept    = dec_valid & dec_ready;
  assign out_load  = ~id_en | id_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // The skid payload is cleared with the control state so a flushed entry
  // can never reappear on id_* later.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= ST_RUN;
      bub_cnt   <= '0;
      skid_full <= 1'b0;
      skid      <= BUNDLE_RST;
      out_q     <= BUNDLE_RST;
      id_en     <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        ST_RUN: begin
          if (ld_hazard) begin
            state   <= ST_BUBBLE;
            bub_cnt <= BUB_INIT;
          end
        end
        ST_BUBBLE: begin
          if (bub_cnt == '0) state <= ST_RUN;
          else               bub_cnt <= bub_cnt - BUB_ONE;
        end
        default: state <= ST_RUN;
      endcase

      // accept implies the skid is empty, so a held output parks the new
      // bundle in the skid and a free output always drains the skid first.
      if (out_load) begin
        if (skid_full) begin
          out_q     <= skid;
          id_en     <= 1'b1;
          skid_full <= 1'b0;
        end else if (accept) begin
          out_q <= in_bundle;
          id_en <= 1'b1;
        end else begin
          id_en <= 1'b0;
        end
      end else if (accept) begin
        skid      <= in_bundle;
        skid_full <= 1'b1;
      end
    end
  end

  assign id_pc          = out_q.pc;
  assign id_alu_op      = out_q.alu_op;
  assign id_alu_in_0    = out_q.alu_in_0;
  assign id_alu_in_1    = out_q.alu_in_1;
  assign id_br_flag     = out_q.br_flag;
  assign id_mem_op      = out_q.mem_op;
  assign id_mem_wr_data = out_q.mem_wr_data;
  assign id_ctrl_op     = out_q.ctrl_op;
  assign id_dst_addr    = out_q.dst_addr;
  assign id_gpr_we_     = out_q.gpr_we_;
  assign id_exp_code    = out_q.exp_code;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe (LD_LAT=2). Directed scenarios are
// followed by randomized traffic; every cycle is compared against a model
// that treats the stage as a 2-deep FIFO plus a bubble lock-out counter.
module tb_id_stage_pipe;

  localparam int LD_LAT = 2;

  typedef struct packed {
    logic [29:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        br;
    logic [1:0]  mem_op;
    logic [31:0] wd;
    logic [1:0]  ctrl;
    logic [4:0]  dst;
    logic        we_;
    logic [2:0]  exp;
  } bnd_t;

  logic        clk = 1'b0;
  logic        reset, flush, stall;
  logic        dec_valid, dec_ready;
  logic [29:0] dec_pc;
  logic [4:0]  dec_rs0, dec_rs1;
  logic        dec_use0, dec_use1;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic        dec_imm_sel;
  logic [31:0] dec_imm;
  logic [3:0]  dec_alu_op;
  logic [1:0]  dec_mem_op, dec_ctrl_op;
  logic [2:0]  dec_exp_code;
  logic        dec_br_flag;
  logic [4:0]  dec_dst_addr;
  logic        dec_gpr_we_;
  logic        ex_en, ex_gpr_we_, ex_is_load;
  logic [4:0]  ex_dst_addr;
  logic [31:0] ex_fwd_data;
  logic        mem_en, mem_gpr_we_;
  logic [4:0]  mem_dst_addr;
  logic [31:0] mem_fwd_data;
  logic        ld_hazard;
  logic        id_ready, id_en;
  logic [29:0] id_pc;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
  logic        id_br_flag;
  logic [1:0]  id_mem_op, id_ctrl_op;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic [2:0]  id_exp_code;

  int   checks = 0;
  int   errors = 0;
  bnd_t mq[$];
  int   lock = 0;
  bnd_t rst_b;
  bnd_t snap;

  always #5 clk = ~clk;

  id_stage_pipe #(.LD_LAT(LD_LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_rs0(dec_rs0), .dec_rs1(dec_rs1), .dec_use0(dec_use0), .dec_use1(dec_use1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .dec_imm_sel(dec_imm_sel), .dec_imm(dec_imm), .dec_alu_op(dec_alu_op),
    .dec_mem_op(dec_mem_op), .dec_ctrl_op(dec_ctrl_op), .dec_exp_code(dec_exp_code),
    .dec_br_flag(dec_br_flag), .dec_dst_addr(dec_dst_addr), .dec_gpr_we_(dec_gpr_we_),
    .ex_en(ex_en), .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_),
    .ex_is_load(ex_is_load), .ex_fwd_data(ex_fwd_data),
    .mem_en(mem_en), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
    .mem_fwd_data(mem_fwd_data), .ld_hazard(ld_hazard), .id_ready(id_ready),
    .id_en(id_en), .id_pc(id_pc), .id_alu_op(id_alu_op), .id_alu_in_0(id_alu_in_0),
    .id_alu_in_1(id_alu_in_1), .id_br_flag(id_br_flag), .id_mem_op(id_mem_op),
    .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr),
    .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code)
  );

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bnd_t dut_bundle();
    bnd_t b;
    b = {id_pc, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag, id_mem_op,
         id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code};
    return b;
  endfunction

  // Operand value an instruction must see: the youngest pending write wins.
  function automatic logic [31:0] ref_operand(input logic use_op, input logic [4:0] rs,
                                              input logic [31:0] gpr);
    if (use_op && ex_en && !ex_gpr_we_ && !ex_is_load && rs == ex_dst_addr) return ex_fwd_data;
    if (use_op && mem_en && !mem_gpr_we_ && rs == mem_dst_addr) return mem_fwd_data;
    return gpr;
  endfunction

  function automatic bnd_t ref_bundle();
    bnd_t b;
    logic [31:0] o1;
    o1       = ref_operand(dec_use1, dec_rs1, gpr_rd_data_1);
    b.pc     = dec_pc;
    b.alu_op = dec_alu_op;
    b.in0    = ref_operand(dec_use0, dec_rs0, gpr_rd_data_0);
    b.in1    = dec_imm_sel ? dec_imm : o1;
    b.br     = dec_br_flag;
    b.mem_op = dec_mem_op;
    b.wd     = o1;
    b.ctrl   = dec_ctrl_op;
    b.dst    = dec_dst_addr;
    b.we_    = dec_gpr_we_;
    b.exp    = dec_exp_code;
    return b;
  endfunction

  function automatic logic ref_hazard();
    return dec_valid && ex_en && ex_is_load && !ex_gpr_we_ &&
           ((dec_use0 && dec_rs0 == ex_dst_addr) || (dec_use1 && dec_rs1 == ex_dst_addr));
  endfunction

  function automatic logic ref_ready();
    return !stall && mq.size() < 2 && lock == 0 && !ref_hazard();
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic acc, hz;
    bnd_t nb;
    @(negedge clk);
    check("dec_ready", dec_ready, ref_ready());
    check("ld_hazard", ld_hazard, ref_hazard());
    check("id_en", id_en, mq.size() > 0);
    if (mq.size() > 0) check("bundle", dut_bundle(), mq[0]);
    @(posedge clk);
    acc = dec_valid && ref_ready();
    hz  = ref_hazard();
    nb  = ref_bundle();
    if (reset || flush) begin
      mq.delete();
      lock = 0;
    end else if (!stall) begin
      if (mq.size() > 0 && id_ready) void'(mq.pop_front());
      if (acc) mq.push_back(nb);
      if (lock > 0) lock--;
      else if (hz) lock = LD_LAT;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; stall = 1'b0; id_ready = 1'b1;
    dec_valid = 1'b0; dec_pc = '0; dec_rs0 = '0; dec_rs1 = '0;
    dec_use0 = 1'b0; dec_use1 = 1'b0; gpr_rd_data_0 = 32'h1111_0000;
    gpr_rd_data_1 = 32'h2222_0000; dec_imm_sel = 1'b0; dec_imm = '0;
    dec_alu_op = 4'h3; dec_mem_op = 2'h1; dec_ctrl_op = 2'h2; dec_exp_code = 3'h5;
    dec_br_flag = 1'b1; dec_dst_addr = 5'd9; dec_gpr_we_ = 1'b0;
    ex_en = 1'b0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1; ex_is_load = 1'b0; ex_fwd_data = '0;
    mem_en = 1'b0; mem_dst_addr = '0; mem_gpr_we_ = 1'b1; mem_fwd_data = '0;
  endtask

  task automatic rand_in();
    reset = ($urandom_range(0, 199) == 0);
    flush = ($urandom_range(0, 39) == 0);
    stall = ($urandom_range(0, 15) == 0);
    id_ready = ($urandom_range(0, 3) != 0);
    dec_valid = ($urandom_range(0, 3) != 0);
    dec_pc = 30'($urandom);
    dec_rs0 = 5'($urandom_range(0, 3));
    dec_rs1 = 5'($urandom_range(0, 3));
    dec_use0 = 1'($urandom); dec_use1 = 1'($urandom);
    gpr_rd_data_0 = $urandom; gpr_rd_data_1 = $urandom;
    dec_imm_sel = 1'($urandom); dec_imm = $urandom;
    dec_alu_op = 4'($urandom); dec_mem_op = 2'($urandom); dec_ctrl_op = 2'($urandom);
    dec_exp_code = 3'($urandom); dec_br_flag = 1'($urandom);
    dec_dst_addr = 5'($urandom_range(0, 3)); dec_gpr_we_ = 1'($urandom);
    ex_en = 1'($urandom); ex_dst_addr = 5'($urandom_range(0, 3));
    ex_gpr_we_ = ($urandom_range(0, 3) == 0); ex_is_load = ($urandom_range(0, 2) == 0);
    ex_fwd_data = $urandom;
    mem_en = 1'($urandom); mem_dst_addr = 5'($urandom_range(0, 3));
    mem_gpr_we_ = ($urandom_range(0, 3) == 0); mem_fwd_data = $urandom;
  endtask

  initial begin
    rst_b = '0;
    rst_b.we_ = 1'b1;
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    check("rst_id_en", id_en, 1'b0);
    check("rst_bundle", dut_bundle(), rst_b);

    // Back-to-back issue, one per cycle, in order.
    for (int i = 0; i < 4; i++) begin
      dec_valid = 1'b1;
      dec_pc = 30'(32'h10 + i);
      step();
      check("t1_id_en", id_en, 1'b1);
      check("t1_pc", id_pc, 32'h10 + i);
    end

    // Forwarding priority.
    dec_pc = 30'h20; dec_use0 = 1'b1; dec_rs0 = 5'd3;
    ex_en = 1'b1; ex_dst_addr = 5'd3; ex_gpr_we_ = 1'b0; ex_fwd_data = 32'hAAAA;
    mem_en = 1'b1; mem_dst_addr = 5'd3; mem_gpr_we_ = 1'b0; mem_fwd_data = 32'h5555;
    step();
    check("t2_ex_over_mem", id_alu_in_0, 32'hAAAA);
    ex_en = 1'b0; dec_pc = 30'h21;
    step();
    check("t2_mem_only", id_alu_in_0, 32'h5555);
    ex_en = 1'b1; dec_use1 = 1'b1; dec_rs1 = 5'd3; dec_pc = 30'h22;
    step();
    check("t2_both_in0", id_alu_in_0, 32'hAAAA);
    check("t2_both_in1", id_alu_in_1, 32'hAAAA);
    check("t2_both_wd", id_mem_wr_data, 32'hAAAA);

    // Load-use interlock.
    idle();
    dec_valid = 1'b1; dec_pc = 30'h30; dec_use0 = 1'b1; dec_rs0 = 5'd5;
    ex_en = 1'b1; ex_is_load = 1'b1; ex_dst_addr = 5'd5; ex_gpr_we_ = 1'b0;
    #1;
    check("t3_hazard", ld_hazard, 1'b1);
    check("t3_hz_ready", dec_ready, 1'b0);
    step();
    check("t3_hold_en", id_en, 1'b0);
    ex_en = 1'b0;
    for (int b = 0; b < LD_LAT; b++) begin
      #1;
      check("t3_bub_ready", dec_ready, 1'b0);
      step();
      check("t3_bub_en", id_en, 1'b0);
    end
    #1;
    check("t3_rel_ready", dec_ready, 1'b1);
    step();
    check("t3_issue_en", id_en, 1'b1);
    check("t3_issue_pc", id_pc, 32'h30);

    // Back-pressure into the skid.
    idle();
    dec_valid = 1'b1; dec_pc = 30'h40; id_ready = 1'b0;
    step();
    dec_pc = 30'h41;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t4_skid_ready", dec_ready, 1'b0);
      step();
    end
    id_ready = 1'b1;
    step();
    check("t4_drain0", id_pc, 32'h40);
    step();
    check("t4_drain1", id_pc, 32'h41);
    dec_valid = 1'b0;
    step();
    check("t4_no_dup", id_en, 1'b0);

    // Flush with skid full while bubbling.
    id_ready = 1'b0; dec_valid = 1'b1; dec_pc = 30'h50;
    step();
    dec_pc = 30'h51;
    step();
    dec_pc = 30'h52; dec_use0 = 1'b1; dec_rs0 = 5'd5;
    ex_en = 1'b1; ex_is_load = 1'b1; ex_dst_addr = 5'd5; ex_gpr_we_ = 1'b0;
    step();
    flush = 1'b1; ex_en = 1'b0;
    step();
    flush = 1'b0; dec_pc = 30'h60;
    check("t5_flush_en", id_en, 1'b0);
    check("t5_flush_bundle", dut_bundle(), rst_b);
    #1;
    check("t5_flush_ready", dec_ready, 1'b1);
    step();
    check("t5_after_pc", id_pc, 32'h60);

    // Stall freeze and immediate select.
    idle();
    dec_valid = 1'b1; dec_pc = 30'h70; dec_imm_sel = 1'b1; dec_imm = 32'h7;
    dec_use1 = 1'b1; dec_rs1 = 5'd2;
    step();
    check("t6_imm", id_alu_in_1, 32'h7);
    snap = dut_bundle();
    stall = 1'b1; dec_pc = 30'h71; dec_imm = 32'h9;
    for (int k = 0; k < 3; k++) begin
      id_ready = 1'($urandom);
      step();
      check("t6_stable", dut_bundle(), snap);
      check("t6_stable_en", id_en, 1'b1);
    end
    stall = 1'b0; id_ready = 1'b1;
    step();
    check("t6_resume_pc", id_pc, 32'h71);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rand_in();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
